spi_ip_slave_engine: RTL and testbench
======================================

# spi_ip_slave_engine

SPI responder (slave) engine for the spi_ip core. It samples the externally driven SCK/SS_n/MOSI, serialises a transmit word onto MISO and deserialises the received word. Frames are word or half-word, MSB- or LSB-first, in all four CPOL/CPHA modes. It is the far end of the link that the master-side shift register path drives, and it presents simple valid/ready parallel ports to the register file.

## Interface
- PARAM_SR_WIDTH, 16, full frame length in bits; must be even, ≥4
- PARAM_SYNC_STAGES, 2, synchroniser depth on SCK/SS_n/MOSI (≥2)

- se_clk_i  in  1  system clock; all logic on rising edge
- se_rst_i  in  1  reset, synchronous, active-high
- se_sck_i  in  1  SPI clock from master, asynchronous
- se_ss_n_i  in  1  slave select, active-low, asynchronous
- se_mosi_i  in  1  serial data from master, asynchronous
- se_miso_o  out  1  serial data to master
- se_miso_oe_o  out  1  MISO output enable (high only while selected)
- se_cpol_i  in  1  SCK idle level
- se_cpha_i  in  1  0: capture on leading edge; 1: launch on leading edge
- se_load_type_i  in  2  bit0: 1 word / 0 half-word; bit1: 1 LSB-first / 0 MSB-first
- se_tx_data_i  in  PARAM_SR_WIDTH  next transmit word
- se_tx_valid_i  in  1  tx word offered
- se_tx_ready_o  out  1  tx holding register empty
- se_rx_data_o  out  PARAM_SR_WIDTH  last completed received frame
- se_rx_valid_o  out  1  one-cycle pulse, se_rx_data_o updated
- se_underrun_o  out  1  one-cycle pulse, frame started with empty tx holding register
- se_busy_o  out  1  frame in progress

## Operation
- SCK, SS_n and MOSI each pass PARAM_SYNC_STAGES flops. A registered copy of synced SCK yields the lead/trail pulses. Leading edge = SCK leaves CPOL level.
- CPHA=0: capture on leading, launch on trailing; first bit is driven at frame start. CPHA=1: launch on leading, capture on trailing.
- Frame length N = PARAM_SR_WIDTH (word) or PARAM_SR_WIDTH/2 (half-word). Half-word frames send tx bits [N-1:0] and return rx in [N-1:0] with the upper half zero.
- Tx holding register: accepted on se_tx_valid_i & se_tx_ready_o. se_tx_ready_o drops the next cycle and rises again when the register is moved into the shifter.
- FSM IDLE -> LOAD -> SHIFT:
  - IDLE: miso_oe=0. Synced SS_n low -> LOAD.
  - LOAD (1 cycle): sample se_load_type_i, se_cpol_i and se_cpha_i for the frame. Copy the holding register to the shifter, or all-zeros plus an underrun pulse if it is empty. Clear the bit counter, assert miso_oe, then go to SHIFT.
  - SHIFT: each capture pulse shifts in MOSI and increments the counter. Each launch pulse advances MISO, except the launch that follows the Nth capture, which is ignored. When the counter reaches N: pulse rx_valid with the assembled word. If SS_n is still low, go to LOAD (back-to-back frame); otherwise go to IDLE.
- Synced SS_n high in SHIFT before N captures: abort. No rx_valid, rx_data unchanged, go to IDLE, holding register untouched.
- A capture and a completion check in the same cycle: the capture counts first.
- se_load_type_i/cpol/cpha changes mid-frame have no effect until the next LOAD.

## Timing
- Reset values: se_miso_o=0, se_miso_oe_o=0, se_tx_ready_o=1, se_rx_data_o=0, se_rx_valid_o=0, se_underrun_o=0, se_busy_o=0, FSM=IDLE, holding register empty.
- Input-to-pulse latency: PARAM_SYNC_STAGES+1 se_clk cycles from a pin edge to the internal lead/trail pulse.
- se_miso_o changes 1 cycle after a launch pulse, or 1 cycle after LOAD for the first bit.
- se_rx_valid_o is asserted the cycle after the Nth capture pulse, for exactly 1 cycle.
- se_busy_o is high from LOAD through the completion/abort cycle.
- Supported SCK: each SCK phase is ≥ PARAM_SYNC_STAGES+2 se_clk cycles. SS_n falling to first SCK edge is ≥ PARAM_SYNC_STAGES+3 cycles.

## Structure
- spi_ip_pkg holds:
  - load-type constants LOAD_HALF_WORD_MSB=2'b00, LOAD_HALF_WORD_LSB=2'b10, LOAD_WORD_MSB=2'b01, LOAD_WORD_LSB=2'b11
  - FSM state encoding
- Sub-module spi_ip_sync_edge: N-stage synchroniser with rise/fall pulse outputs, instantiated for SCK and SS_n. MOSI uses the synchroniser only.

## Test plan
- Mode 0, LOAD_WORD_MSB, tx 0x1234, master sends 0x4321 -> MISO bit stream 0x1234 MSB-first, rx_data 0x4321, one rx_valid pulse.
- Mode 3, LOAD_WORD_LSB, tx 0x1e6a, master sends 0xa6e1 -> MISO 0x1e6a LSB-first, rx_data 0xa6e1.
- Mode 1, LOAD_HALF_WORD_MSB, tx 0xff12, master sends 0x34 -> MISO 0x12 MSB-first, rx_data 0x0034. Then mode 2, LOAD_HALF_WORD_LSB, tx 0xbb6a, master 0x1e -> MISO 0x6a LSB-first, rx_data 0x001e.
- Back-to-back: SS_n held low, tx 0xaaaa then 0x5555 queued via handshake, master sends 0x0f0f, 0xf0f0 -> two rx_valid pulses with matching data. tx_ready rises after each LOAD.
- Abort and underrun: no tx queued, SS_n low -> underrun pulse, MISO all zeros. SS_n raised after 7 bits -> no rx_valid, miso_oe=0, IDLE.
- se_rst_i asserted mid-frame -> all outputs at reset values the next cycle. A fresh frame afterwards completes correctly.

Source files
------------

// File: rtl/spi_ip_pkg.sv
// Shared definitions for the spi_ip responder engine: load-type encodings and
// the frame-sequencer state type.
package spi_ip_pkg;

  // se_load_type_i encoding: bit0 selects word (1) / half-word (0),
  // bit1 selects LSB-first (1) / MSB-first (0).
  localparam logic [1:0] LOAD_HALF_WORD_MSB = 2'b00;
  localparam logic [1:0] LOAD_HALF_WORD_LSB = 2'b10;
  localparam logic [1:0] LOAD_WORD_MSB      = 2'b01;
  localparam logic [1:0] LOAD_WORD_LSB      = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } se_state_e;

endpackage

// File: rtl/spi_ip_slave_engine_if.sv
// Parallel-side port bundle between the responder engine and the register file.
interface spi_ip_slave_engine_if #(
  parameter int PARAM_SR_WIDTH = 16
);
  logic [PARAM_SR_WIDTH-1:0] se_tx_data_i;
  logic                      se_tx_valid_i;
  logic                      se_tx_ready_o;
  logic [PARAM_SR_WIDTH-1:0] se_rx_data_o;
  logic                      se_rx_valid_o;
  logic                      se_underrun_o;
  logic                      se_busy_o;

  // Engine side.
  modport slave (
    input  se_tx_data_i, se_tx_valid_i,
    output se_tx_ready_o, se_rx_data_o, se_rx_valid_o, se_underrun_o, se_busy_o
  );

  // Register-file side.
  modport master (
    output se_tx_data_i, se_tx_valid_i,
    input  se_tx_ready_o, se_rx_data_o, se_rx_valid_o, se_underrun_o, se_busy_o
  );
endinterface

// File: rtl/spi_ip_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle rise/fall
// pulses derived from a registered copy of the synchronised level.
module spi_ip_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_sync;

  assign w_sync = r_sync[STAGES-1];

  // Synchroniser chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      // NOTE: non-blocking, so every stage takes its neighbour's old value and the chain really is STAGES flops deep.
      r_sync <= {r_sync[STAGES-2:0], async_i};
      r_prev <= w_sync;
    end
  end

  assign sync_o = w_sync;
  assign rise_o = w_sync & ~r_prev;
  assign fall_o = ~w_sync & r_prev;

endmodule

// File: rtl/spi_ip_slave_engine.sv
// SPI responder engine: synchronises SCK/SS_n/MOSI, shifts a transmit word out
// on MISO and assembles the received word, in all CPOL/CPHA modes, word or
// half-word, MSB- or LSB-first.
module spi_ip_slave_engine
  import spi_ip_pkg::*;
#(
  parameter int PARAM_SR_WIDTH    = 16,
  parameter int PARAM_SYNC_STAGES = 2
) (
  input  logic       se_clk_i,
  input  logic       se_rst_i,
  input  logic       se_sck_i,
  input  logic       se_ss_n_i,
  input  logic       se_mosi_i,
  output logic       se_miso_o,
  output logic       se_miso_oe_o,
  input  logic       se_cpol_i,
  input  logic       se_cpha_i,
  input  logic [1:0] se_load_type_i,
  spi_ip_slave_engine_if.slave se_bus
);

  localparam int W     = PARAM_SR_WIDTH;
  localparam int H     = PARAM_SR_WIDTH / 2;
  localparam int CNT_W = $clog2(PARAM_SR_WIDTH + 1);
  localparam logic [CNT_W-1:0] LEN_WORD = CNT_W'(W);
  localparam logic [CNT_W-1:0] LEN_HALF = CNT_W'(H);

  se_state_e r_state, w_state_next;

  // Synchronised pins and SCK edges.
  logic w_sck, w_sck_rise, w_sck_fall;
  logic w_ss_n, w_ss_rise, w_ss_fall;
  logic [PARAM_SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;
  logic w_unused_sync;

  // Frame configuration captured in LOAD.
  logic r_cpol, r_cpha, r_half, r_lsb;

  // Holding register and shift datapath.
  logic [W-1:0]     r_hold;
  logic             r_hold_full;
  logic [W-1:0]     r_tx_sr;
  logic [W-1:0]     r_rx_sr;
  logic [CNT_W-1:0] r_bit_cnt;

  // Registered outputs.
  logic         r_miso, r_miso_oe, r_rx_valid, r_underrun;
  logic [W-1:0] r_rx_data;

  // Combinational helpers.
  logic             w_lead, w_trail, w_capture, w_launch, w_done, w_oe_next;
  logic [CNT_W-1:0] w_frame_len, w_cnt_next;
  logic [W-1:0]     w_rx_next, w_rx_word, w_tx_fmt;
  logic             w_tx_head, w_first_bit;

  spi_ip_sync_edge #(.STAGES(PARAM_SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk_i  (se_clk_i),
    .rst_i  (se_rst_i),
    .async_i(se_sck_i),
    .sync_o (w_sck),
    .rise_o (w_sck_rise),
    .fall_o (w_sck_fall)
  );

  // SS_n resets to the deselected level so reset never looks like a select.
  spi_ip_sync_edge #(.STAGES(PARAM_SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk_i  (se_clk_i),
    .rst_i  (se_rst_i),
    .async_i(se_ss_n_i),
    .sync_o (w_ss_n),
    .rise_o (w_ss_rise),
    .fall_o (w_ss_fall)
  );

  // The FSM works on the SS_n level and on SCK edges only.
  assign w_unused_sync = w_sck ^ w_ss_rise ^ w_ss_fall;

  // MOSI synchroniser, same depth as SCK so data and edge line up.
  always_ff @(posedge se_clk_i) begin
    if (se_rst_i) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[PARAM_SYNC_STAGES-2:0], se_mosi_i};
  end
  assign w_mosi = r_mosi_sync[PARAM_SYNC_STAGES-1];

  // Leading edge leaves the CPOL level; CPHA picks which edge captures.
  assign w_lead    = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail   = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_capture = (r_state == ST_SHIFT) && (r_cpha ? w_trail : w_lead);
  assign w_launch  = (r_state == ST_SHIFT) && (r_cpha ? w_lead : w_trail);

  // The capture in this cycle is counted before the completion test.
  assign w_frame_len = r_half ? LEN_HALF : LEN_WORD;
  assign w_cnt_next  = r_bit_cnt + {{(CNT_W-1){1'b0}}, w_capture};
  assign w_done      = (r_state == ST_SHIFT) && (w_cnt_next == w_frame_len);

  // A launch drives the bit indexed by the number of captures so far. The
  // tx shifter advances on capture, so its head is always that bit; the
  // redundant launch after the last capture just re-drives the next head.
  assign w_tx_head = r_lsb ? r_tx_sr[0] : r_tx_sr[W-1];

  // Received word including this cycle's capture; LSB-first half-words land
  // in the upper half of the shifter and are moved down on completion.
  always_comb begin
    w_rx_next = r_rx_sr;
    if (w_capture) begin
      w_rx_next = r_lsb ? {w_mosi, r_rx_sr[W-1:1]} : {r_rx_sr[W-2:0], w_mosi};
    end
    w_rx_word = (r_lsb && r_half) ? (w_rx_next >> H) : w_rx_next;
  end

  // Format the holding register for the shifter so the first bit out is
  // always at the head for the chosen bit order; empty gives all zeros.
  always_comb begin
    // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
    w_tx_fmt = '0;
    if (r_hold_full) begin
      case (se_load_type_i)
        LOAD_HALF_WORD_MSB: w_tx_fmt = {r_hold[H-1:0], {H{1'b0}}};
        LOAD_HALF_WORD_LSB: w_tx_fmt = {{H{1'b0}}, r_hold[H-1:0]};
        default:            w_tx_fmt = r_hold;
      endcase
    end
    w_first_bit = se_load_type_i[1] ? w_tx_fmt[0] : w_tx_fmt[W-1];
  end

  // Next-state and MISO-enable decode.
  always_comb begin
    w_state_next = r_state;
    w_oe_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_ss_n) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_next = ST_SHIFT;
        w_oe_next    = 1'b1;
      end
      ST_SHIFT: begin
        if (w_done)      w_state_next = w_ss_n ? ST_IDLE : ST_LOAD;
        else if (w_ss_n) w_state_next = ST_IDLE;
        w_oe_next = (w_state_next != ST_IDLE);
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge se_clk_i) begin
    if (se_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Holding register, frame configuration, shifters and output registers.
  always_ff @(posedge se_clk_i) begin
    if (se_rst_i) begin
      // NOTE: data registers are reset as well, because rx data and MISO have defined reset values.
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_half      <= 1'b0;
      r_lsb       <= 1'b0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_miso_oe  <= w_oe_next;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      if (se_bus.se_tx_valid_i && !r_hold_full) begin
        r_hold      <= se_bus.se_tx_data_i;
        r_hold_full <= 1'b1;
      end

      case (r_state)
        ST_IDLE: r_miso <= 1'b0;
        ST_LOAD: begin
          r_cpol    <= se_cpol_i;
          r_cpha    <= se_cpha_i;
          r_half    <= ~se_load_type_i[0];
          r_lsb     <= se_load_type_i[1];
          r_tx_sr   <= w_tx_fmt;
          r_miso    <= w_first_bit;
          r_rx_sr   <= '0;
          r_bit_cnt <= '0;
          if (r_hold_full) r_hold_full <= 1'b0;
          else             r_underrun  <= 1'b1;
        end
        ST_SHIFT: begin
          if (w_capture) begin
            r_rx_sr   <= w_rx_next;
            r_bit_cnt <= w_cnt_next;
            r_tx_sr   <= r_lsb ? {1'b0, r_tx_sr[W-1:1]} : {r_tx_sr[W-2:0], 1'b0};
          end
          if (w_launch) r_miso <= w_tx_head;
          if (w_done) begin
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign se_miso_o            = r_miso;
  assign se_miso_oe_o         = r_miso_oe;
  assign se_bus.se_tx_ready_o = ~r_hold_full;
  assign se_bus.se_rx_data_o  = r_rx_data;
  assign se_bus.se_rx_valid_o = r_rx_valid;
  assign se_bus.se_underrun_o = r_underrun;
  assign se_bus.se_busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_ip_slave_engine.sv
// Directed plus randomised bench for spi_ip_slave_engine. The bench plays the
// SPI master bit by bit and judges MISO/rx data against the words as plain
// numbers masked to the frame length.
module tb_spi_ip_slave_engine;
  import spi_ip_pkg::*;

  localparam int HP = 8;  // SCK half period in system clocks

  logic       clk = 1'b0;
  logic       rst;
  logic       sck, ss_n, mosi, cpol, cpha;
  logic [1:0] load_type;
  logic       miso, miso_oe;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int un_cnt   = 0;
  logic [15:0] last_rx = '0;
  logic [15:0] exp_rx_last;

  spi_ip_slave_engine_if #(.PARAM_SR_WIDTH(16)) bus ();

  spi_ip_slave_engine #(.PARAM_SR_WIDTH(16), .PARAM_SYNC_STAGES(2)) dut (
    .se_clk_i      (clk),
    .se_rst_i      (rst),
    .se_sck_i      (sck),
    .se_ss_n_i     (ss_n),
    .se_mosi_i     (mosi),
    .se_miso_o     (miso),
    .se_miso_oe_o  (miso_oe),
    .se_cpol_i     (cpol),
    .se_cpha_i     (cpha),
    .se_load_type_i(load_type),
    .se_bus        (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts every cycle rx_valid / underrun is high.
  always @(negedge clk) begin
    if (bus.se_rx_valid_o) begin
      rx_cnt++;
      last_rx = bus.se_rx_data_o;
    end
    if (bus.se_underrun_o) un_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic p, input logic h, input logic [1:0] lt);
    cpol = p; cpha = h; load_type = lt; sck = p;
    cyc(4);
  endtask

  task automatic push_tx(input logic [15:0] d);
    int t;
    t = 0;
    bus.se_tx_data_i  = d;
    bus.se_tx_valid_i = 1'b1;
    @(negedge clk);
    while (!bus.se_tx_ready_o && t < 200) begin
      t++;
      @(negedge clk);
    end
    check("tx_accept_in_time", 16'(t < 200), 16'd1);
    @(posedge clk);
    #1;
    bus.se_tx_valid_i = 1'b0;
  endtask

  // Master side of one frame (SS_n already low): drives MOSI, toggles SCK,
  // samples MISO at the master's capture point.
  task automatic shift_bits(input int n, input logic [15:0] m, input logic lsb,
                            input logic p, input logic h, input int nsend,
                            output logic [15:0] got);
    logic b;
    got = '0;
    for (int k = 0; k < nsend; k++) begin
      if (!h) begin
        mosi = lsb ? m[k] : m[n-1-k];
        cyc(HP);
        b = miso;
        sck = ~p;
        cyc(HP);
        sck = p;
      end else begin
        sck = ~p;
        mosi = lsb ? m[k] : m[n-1-k];
        cyc(HP);
        b = miso;
        sck = p;
        cyc(HP);
      end
      if (k == 0) check("miso_oe_in_frame", 16'(miso_oe), 16'd1);
      if (lsb) got[k] = b;
      else     got[n-1-k] = b;
    end
  endtask

  // One complete frame with a queued tx word. SS_n is still low when the
  // frame completes, so the engine reloads with an empty holding register:
  // one underrun pulse per frame, then SS_n high aborts that reload.
  task automatic single_frame(input string tag, input logic p, input logic h,
                              input logic [1:0] lt, input logic [15:0] tx,
                              input logic [15:0] m);
    int n, rx0, u0;
    logic [15:0] mask, got;
    n    = lt[0] ? 16 : 8;
    mask = lt[0] ? 16'hffff : 16'h00ff;
    set_mode(p, h, lt);
    push_tx(tx);
    rx0 = rx_cnt; u0 = un_cnt;
    ss_n = 1'b0;
    cyc(HP);
    shift_bits(n, m, lt[1], p, h, n, got);
    cyc(HP);
    ss_n = 1'b1;
    cyc(8);
    exp_rx_last = m & mask;
    check({tag, "_miso"},     got, tx & mask);
    check({tag, "_rx_data"},  last_rx, exp_rx_last);
    check({tag, "_rx_pulse"}, 16'(rx_cnt - rx0), 16'd1);
    check({tag, "_underrun"}, 16'(un_cnt - u0), 16'd1);
    check({tag, "_oe_idle"},  16'(miso_oe), 16'd0);
    check({tag, "_busy"},     16'(bus.se_busy_o), 16'd0);
  endtask

  initial begin
    logic [15:0] got1, got2;
    int rx0, u0;
    rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; load_type = LOAD_WORD_MSB;
    bus.se_tx_data_i = '0; bus.se_tx_valid_i = 1'b0;
    exp_rx_last = '0;
    cyc(3);

    // Reset state.
    check("rst_miso",     16'(miso), 16'd0);
    check("rst_miso_oe",  16'(miso_oe), 16'd0);
    check("rst_tx_ready", 16'(bus.se_tx_ready_o), 16'd1);
    check("rst_rx_data",  bus.se_rx_data_o, 16'h0000);
    check("rst_rx_valid", 16'(bus.se_rx_valid_o), 16'd0);
    check("rst_underrun", 16'(bus.se_underrun_o), 16'd0);
    check("rst_busy",     16'(bus.se_busy_o), 16'd0);
    rst = 1'b0;
    cyc(5);

    // Directed frames in all four modes and all load types.
    single_frame("m0_word_msb", 1'b0, 1'b0, LOAD_WORD_MSB,      16'h1234, 16'h4321);
    single_frame("m3_word_lsb", 1'b1, 1'b1, LOAD_WORD_LSB,      16'h1e6a, 16'ha6e1);
    single_frame("m1_half_msb", 1'b0, 1'b1, LOAD_HALF_WORD_MSB, 16'hff12, 16'h0034);
    single_frame("m2_half_lsb", 1'b1, 1'b0, LOAD_HALF_WORD_LSB, 16'hbb6a, 16'h001e);

    // Back-to-back frames with SS_n held low.
    set_mode(1'b0, 1'b0, LOAD_WORD_MSB);
    push_tx(16'haaaa);
    check("b2b_ready_drop", 16'(bus.se_tx_ready_o), 16'd0);
    rx0 = rx_cnt; u0 = un_cnt;
    ss_n = 1'b0;
    push_tx(16'h5555);
    check("b2b_ready_held", 16'(bus.se_tx_ready_o), 16'd0);
    cyc(HP);
    shift_bits(16, 16'h0f0f, 1'b0, 1'b0, 1'b0, 16, got1);
    check("b2b_f1_pulse", 16'(rx_cnt - rx0), 16'd1);
    check("b2b_f1_rx",    last_rx, 16'h0f0f);
    check("b2b_ready_after_load", 16'(bus.se_tx_ready_o), 16'd1);
    shift_bits(16, 16'hf0f0, 1'b0, 1'b0, 1'b0, 16, got2);
    cyc(HP);
    ss_n = 1'b1;
    cyc(8);
    check("b2b_f1_miso",  got1, 16'haaaa);
    check("b2b_f2_miso",  got2, 16'h5555);
    check("b2b_f2_pulse", 16'(rx_cnt - rx0), 16'd2);
    check("b2b_f2_rx",    last_rx, 16'hf0f0);
    check("b2b_underrun", 16'(un_cnt - u0), 16'd1);
    exp_rx_last = 16'hf0f0;

    // Underrun then abort after 7 bits.
    set_mode(1'b0, 1'b0, LOAD_WORD_MSB);
    rx0 = rx_cnt; u0 = un_cnt;
    ss_n = 1'b0;
    cyc(HP);
    check("abort_underrun", 16'(un_cnt - u0), 16'd1);
    check("abort_busy_in_frame", 16'(bus.se_busy_o), 16'd1);
    shift_bits(16, 16'hbeef, 1'b0, 1'b0, 1'b0, 7, got1);
    ss_n = 1'b1;
    cyc(8);
    check("abort_miso_zero", got1, 16'h0000);
    check("abort_no_rx",     16'(rx_cnt - rx0), 16'd0);
    check("abort_rx_kept",   bus.se_rx_data_o, exp_rx_last);
    check("abort_oe",        16'(miso_oe), 16'd0);
    check("abort_busy",      16'(bus.se_busy_o), 16'd0);
    check("abort_ready",     16'(bus.se_tx_ready_o), 16'd1);
    check("abort_one_underrun", 16'(un_cnt - u0), 16'd1);

    // Reset in the middle of a frame.
    set_mode(1'b0, 1'b0, LOAD_WORD_MSB);
    push_tx(16'h1357);
    ss_n = 1'b0;
    cyc(HP);
    shift_bits(16, 16'h2468, 1'b0, 1'b0, 1'b0, 5, got1);
    rst = 1'b1; ss_n = 1'b1; sck = 1'b0;
    cyc(1);
    check("mrst_miso",     16'(miso), 16'd0);
    check("mrst_miso_oe",  16'(miso_oe), 16'd0);
    check("mrst_tx_ready", 16'(bus.se_tx_ready_o), 16'd1);
    check("mrst_rx_data",  bus.se_rx_data_o, 16'h0000);
    check("mrst_rx_valid", 16'(bus.se_rx_valid_o), 16'd0);
    check("mrst_underrun", 16'(bus.se_underrun_o), 16'd0);
    check("mrst_busy",     16'(bus.se_busy_o), 16'd0);
    cyc(2);
    rst = 1'b0;
    cyc(5);
    single_frame("post_rst", 1'b0, 1'b0, LOAD_WORD_MSB, 16'hc3a5, 16'h5a3c);

    // Randomised frames across modes and load types.
    for (int i = 0; i < 6; i++) begin
      single_frame($sformatf("rand%0d", i),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
